// File: rtl/seven_seg_display_ctrl.sv
// Four-digit seven-segment scan controller: hex decode, blanking, dp, leading-zero suppression, PWM brightness.
// Latency: anode/seg/dp/frame_done are registered one div_clock after the scan state they reflect.
// Backpressure: load_ready drops while a load is pending; pending contents move to the shadow at frame end.
module seven_seg_display_ctrl #(
  parameter int DWELL_CYCLES = 8
) (
  input  logic        div_clock,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  load_blank,
  input  logic        lzs,
  input  logic [3:0]  bright,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam logic [3:0] DWELL_LAST = 4'(DWELL_CYCLES - 1);

  logic [3:0]  dwell_cnt;
  logic [15:0] shadow_value, pend_value;
  logic [3:0]  shadow_dp, shadow_blank, pend_dp, pend_blank;
  logic        pend_flag;
  logic        slot_end, boundary;
  logic [3:0]  nibble, anode_sel, anode_nxt;
  logic [6:0]  hex_seg, seg_nxt;
  logic        dp_nxt, suppressed, lit;

  assign slot_end   = (dwell_cnt == DWELL_LAST);
  assign boundary   = slot_end && (digit_sel == 2'd3);
  assign load_ready = ~pend_flag;

  // A digit is suppressed only when it and every higher nibble are zero.
  always_comb begin
    nibble     = 4'd0;
    anode_sel  = 4'b1111;
    suppressed = 1'b0;
    case (digit_sel)
      2'd0: begin
        nibble    = shadow_value[3:0];
        anode_sel = 4'b1110;
      end
      2'd1: begin
        nibble     = shadow_value[7:4];
        anode_sel  = 4'b1101;
        suppressed = lzs && (shadow_value[15:4] == 12'd0);
      end
      2'd2: begin
        nibble     = shadow_value[11:8];
        anode_sel  = 4'b1011;
        suppressed = lzs && (shadow_value[15:8] == 8'd0);
      end
      default: begin
        nibble     = shadow_value[15:12];
        anode_sel  = 4'b0111;
        suppressed = lzs && (shadow_value[15:12] == 4'd0);
      end
    endcase
    lit = (dwell_cnt < bright) && !shadow_blank[digit_sel] && !suppressed;
  end

  always_comb begin
    hex_seg = 7'b1111111;
    case (nibble)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
    anode_nxt = lit ? anode_sel : 4'b1111;
    seg_nxt   = lit ? hex_seg : 7'b1111111;
    dp_nxt    = lit ? ~shadow_dp[digit_sel] : 1'b1;
  end

  always_ff @(posedge div_clock) begin
    if (reset) begin
      dwell_cnt    <= 4'd0;
      digit_sel    <= 2'd0;
      shadow_value <= 16'd0;
      shadow_dp    <= 4'd0;
      shadow_blank <= 4'b1111;
      pend_value   <= 16'd0;
      pend_dp      <= 4'd0;
      pend_blank   <= 4'd0;
      pend_flag    <= 1'b0;
      anode        <= 4'b1111;
      seg          <= 7'b1111111;
      dp           <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      if (slot_end) begin
        dwell_cnt <= 4'd0;
        digit_sel <= digit_sel + 2'd1;
      end else begin
        dwell_cnt <= dwell_cnt + 4'd1;
      end
      // Swap only at the frame boundary so a frame never mixes old and new contents.
      if (boundary && pend_flag) begin
        shadow_value <= pend_value;
        shadow_dp    <= pend_dp;
        shadow_blank <= pend_blank;
        pend_flag    <= 1'b0;
      end else if (load_valid && !pend_flag) begin
        pend_value <= load_value;
        pend_dp    <= load_dp;
        pend_blank <= load_blank;
        pend_flag  <= 1'b1;
      end
      anode      <= anode_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed bench for seven_seg_display_ctrl with DWELL_CYCLES=8: vector table plus hand sequences.
module tb_seven_seg_display_ctrl;

  logic        div_clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_value = 16'd0;
  logic [3:0]  load_dp = 4'd0;
  logic [3:0]  load_blank = 4'd0;
  logic        lzs = 1'b0;
  logic [3:0]  bright = 4'd8;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_display_ctrl #(.DWELL_CYCLES(8)) dut (
    .div_clock (div_clock),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .load_dp   (load_dp),
    .load_blank(load_blank),
    .lzs       (lzs),
    .bright    (bright),
    .anode     (anode),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  always #5 div_clock = ~div_clock;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dpv;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][3:0] an;   // expected anode per digit {d3,d2,d1,d0}
    logic [3:0][6:0] sg;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge div_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_chk(input string name, input int n, input int limit);
    n_cmp++;
    if (n >= limit) begin
      n_bad++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, n, limit);
    end
  endtask

  // Wait for the first frame start after the pending contents were applied.
  task automatic wait_applied();
    int n = 0;
    while (!(frame_done && load_ready) && n < 200) begin
      tick();
      n++;
    end
    bound_chk("wait_applied_timeout", n, 200);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    int n = 0;
    while (!load_ready && n < 200) begin
      tick();
      n++;
    end
    bound_chk("wait_ready_timeout", n, 200);
    load_valid = 1'b1;
    load_value = v;
    load_dp    = d;
    load_blank = b;
    tick();
    load_valid = 1'b0;
    chk("ready_low_after_xfer", 32'(load_ready), 32'd0);
    wait_applied();
  endtask

  // Called at the frame-start cycle; samples each digit mid-slot.
  task automatic check_frame(input vec_t v, input string tag);
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c % 8 == 4) begin
        int k = c / 8;
        chk($sformatf("%s_anode_d%0d", tag, k), 32'(anode), 32'(v.an[k]));
        chk($sformatf("%s_seg_d%0d", tag, k), 32'(seg), 32'(v.sg[k]));
        chk($sformatf("%s_dp_d%0d", tag, k), 32'(dp), 32'(v.dpo[k]));
        chk($sformatf("%s_sel_d%0d", tag, k), 32'(digit_sel), 32'(k));
      end
    end
  endtask

  // Called in the first cycle after reset; display must stay dark for two frames.
  task automatic check_idle(input string tag);
    chk({tag, "_anode0"}, 32'(anode), 32'hF);
    chk({tag, "_seg0"}, 32'(seg), 32'h7F);
    chk({tag, "_dp0"}, 32'(dp), 32'd1);
    chk({tag, "_fd0"}, 32'(frame_done), 32'd0);
    chk({tag, "_ready0"}, 32'(load_ready), 32'd1);
    chk({tag, "_sel0"}, 32'(digit_sel), 32'd0);
    for (int t = 1; t <= 64; t++) begin
      tick();
      chk($sformatf("%s_anode_t%0d", tag, t), 32'(anode), 32'hF);
      chk($sformatf("%s_sel_t%0d", tag, t), 32'(digit_sel), 32'((t / 8) % 4));
      chk($sformatf("%s_fd_t%0d", tag, t), 32'(frame_done), 32'(t % 32 == 0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{16'h12AF, 4'b0100, 4'b0000, 1'b0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1011};
    vecs[1] = '{16'h3456, 4'b0000, 4'b0000, 1'b0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 4'b1111};
    vecs[2] = '{16'h789B, 4'b0000, 4'b0000, 1'b0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111000, 7'b0000000, 7'b0010000, 7'b0000011}, 4'b1111};
    vecs[3] = '{16'hCDE0, 4'b1001, 4'b0000, 1'b0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}, 4'b0110};
    vecs[4] = '{16'h0050, 4'b0000, 4'b0000, 1'b1,
                {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
    vecs[5] = '{16'h0000, 4'b0000, 4'b0000, 1'b1,
                {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vecs[6] = '{16'h0000, 4'b1111, 4'b0101, 1'b0,
                {4'b0111, 4'b1111, 4'b1101, 4'b1111},
                {7'b1000000, 7'b1111111, 7'b1000000, 7'b1111111}, 4'b0101};
    vecs[7] = '{16'h0105, 4'b1000, 4'b0000, 1'b1,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1111001, 7'b1000000, 7'b0010010}, 4'b1111};

    repeat (3) tick();
    reset = 1'b0;
    check_idle("idle");

    // Handshake: a second offer during the pending window must be ignored.
    n = 0;
    while (digit_sel != 2'd1 && n < 100) begin
      tick();
      n++;
    end
    bound_chk("wait_sel1_timeout", n, 100);
    load_valid = 1'b1;
    load_value = vecs[0].value;
    load_dp    = vecs[0].dpv;
    load_blank = vecs[0].blank;
    tick();
    load_value = 16'hFFFF;
    load_dp    = 4'b1111;
    load_blank = 4'b0000;
    n = 0;
    while (!frame_done && n < 100) begin
      chk("hs_ready_low", 32'(load_ready), 32'd0);
      tick();
      n++;
    end
    bound_chk("hs_boundary_timeout", n, 100);
    chk("hs_ready_back", 32'(load_ready), 32'd1);
    load_valid = 1'b0;
    check_frame(vecs[0], "hs");

    for (int i = 0; i < 8; i++) begin
      lzs = vecs[i].lz;
      do_load(vecs[i].value, vecs[i].dpv, vecs[i].blank);
      check_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Brightness: only digit 0 unblanked.
    lzs = 1'b0;
    do_load(16'h0000, 4'b0000, 4'b1110);
    bright = 4'd3;
    for (int j = 0; j < 32; j++) begin
      tick();
      chk($sformatf("br3_j%0d", j), 32'(anode), (j < 3) ? 32'hE : 32'hF);
    end
    bright = 4'd0;
    for (int j = 0; j < 32; j++) begin
      tick();
      chk($sformatf("br0_j%0d", j), 32'(anode), 32'hF);
    end
    bright = 4'd15;
    for (int j = 0; j < 32; j++) begin
      tick();
      chk($sformatf("br15_j%0d", j), 32'(anode), (j < 8) ? 32'hE : 32'hF);
    end
    bright = 4'd8;

    // lzs change is visible one cycle later, mid-frame.
    lzs = 1'b1;
    do_load(16'h0000, 4'b0000, 4'b0000);
    repeat (27) tick();
    chk("lzs_on_d3_anode", 32'(anode), 32'hF);
    lzs = 1'b0;
    tick();
    chk("lzs_off_d3_anode", 32'(anode), 32'h7);
    chk("lzs_off_d3_seg", 32'(seg), 32'h40);

    // Reset mid-frame with a load pending.
    n = 0;
    while (!load_ready && n < 100) begin
      tick();
      n++;
    end
    bound_chk("rst_ready_timeout", n, 100);
    load_valid = 1'b1;
    load_value = 16'h8888;
    load_dp    = 4'b1111;
    load_blank = 4'b0000;
    tick();
    load_valid = 1'b0;
    chk("rst_pending", 32'(load_ready), 32'd0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
Scheduler for the 4-digit seven-segment display. It time-multiplexes the four digits on div_clock and decodes hex nibbles to segments. It adds per-digit blanking, decimal points, leading-zero suppression and PWM brightness. New display contents are accepted through a valid/ready handshake and applied only at frame boundaries, so a half-updated frame is never shown.

Parameters:
DWELL_CYCLES, 8, div_clock cycles per digit slot; legal range 2..15.

Ports:
div_clock  in   1   scan clock; all state is updated on its rising edge
reset      in   1   synchronous, active-high reset
load_valid in   1   new display contents offered
load_ready out  1   controller can accept contents
load_value in   16  four hex nibbles; [3:0] = digit 0 (rightmost)
load_dp    in   4   decimal point per digit, 1 = on
load_blank in   4   per-digit forced blank, 1 = blank
lzs        in   1   leading-zero suppression enable, sampled every cycle
bright     in   4   on-cycles per slot; 0 = dark, >= DWELL_CYCLES = full
anode      out  4   active-low digit enables
seg        out  7   active-low cathodes {g,f,e,d,c,b,a}
dp         out  1   active-low decimal point
digit_sel  out  2   slot currently scanned
frame_done out  1   one-cycle pulse per completed frame

Behaviour:
- State registers:
  - dwell_cnt, 4 bits, counts 0..DWELL_CYCLES-1.
  - digit_sel, 2 bits.
  - Shadow set: value, dp, blank.
  - Pending set: value, dp, blank, plus a pending flag.
- Reset values: dwell_cnt=0, digit_sel=0, shadow value=0, shadow dp=0, shadow blank=4'b1111, pending flag=0, load_ready=1, anode=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
- Scan:
  - dwell_cnt increments every cycle.
  - When dwell_cnt reaches DWELL_CYCLES-1 it wraps to 0 and digit_sel increments 0->1->2->3->0 (2-bit wrap).
  - A frame is 4*DWELL_CYCLES cycles.
- Boundary cycle: digit_sel=3 and dwell_cnt=DWELL_CYCLES-1.
- Anode mapping for the selected digit: digit 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111. At most one anode is low at any time.
- A digit is lit when all of the following hold:
  - dwell_cnt < bright;
  - shadow blank[digit_sel] = 0;
  - the digit is not suppressed by lzs.
- When not lit: anode=1111, seg=1111111, dp=1.
- Leading-zero suppression (lzs=1): digit k (k = 3, 2 or 1) is suppressed when its nibble and all higher nibbles are 0. Digit 0 is never suppressed. Suppression is evaluated on the shadow value.
- Hex decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- dp output = ~shadow dp[digit_sel], and only while the digit is lit.
- Output timing: anode, seg, dp and frame_done are registered. The output in cycle n+1 reflects state and inputs in cycle n (1-cycle latency). digit_sel is the state register itself.
- frame_done goes high for exactly one cycle, the cycle after each boundary cycle.
- Handshake:
  - A transfer occurs when load_valid=1 and load_ready=1 in the same cycle. The inputs are captured into the pending set and the pending flag is set.
  - load_ready=0 from the next cycle while the pending flag is set.
  - load_valid while load_ready=0 is ignored; no capture and no error.
  - At the boundary cycle, if the pending flag is set, the pending set is copied to the shadow and the flag is cleared. load_ready returns to 1 in the next cycle. The new contents are first displayed on digit 0 of the next frame.
- Transfer in the boundary cycle with the pending flag clear: contents go to pending and are applied at the following boundary. There is no bypass into the shadow.
- Changes to bright and lzs take effect on the next cycle; they do not wait for a frame boundary.
- Reset at any point, including mid-frame or with a load pending, returns every register to its reset value. Pending contents are discarded.

Test Plan:
- Idle after reset (DWELL_CYCLES=8) -> anode=1111 on every cycle; digit_sel steps every 8 cycles; frame_done pulses once every 32 cycles, first pulse 32 cycles after reset release.
- Load 0x12AF, dp=0100, blank=0000, bright=8 mid-frame -> first frame after the next boundary shows:
  - digit 0: anode 1110, seg 0001110
  - digit 1: anode 1101, seg 0001000
  - digit 2: anode 1011, seg 0100100, dp=0
  - digit 3: anode 0111, seg 1111001
- Handshake -> load_ready=0 from the cycle after the transfer until the cycle after the boundary. A second load_valid with 0xFFFF during that window is ignored, and the display shows the first value.
- Brightness with digit 0 lit -> bright=3: anode low for exactly dwell_cnt 0..2 of each 8-cycle slot; bright=0: anode=1111 always; bright=15: anode low for all 8 cycles.
- Leading-zero suppression, lzs=1 -> value 0x0050: digits 3 and 2 dark, digits 1 ('5', seg 0010010) and 0 ('0', seg 1000000) lit. Value 0x0000: only digit 0 lit. Set lzs=0 -> all four lit on the next cycle.
- Reset asserted for 1 cycle mid-frame with a load pending -> next cycle: anode=1111, load_ready=1, digit_sel=0. The pending value never appears, and frame_done pulses 32 cycles after reset release.
